focus_sharpness_acc: RTL and testbench
======================================

Name: focus_sharpness_acc

Overview:
Per-frame focus-measure engine feeding the VCM step controller in the autofocus path. It converts incoming RGB video to luma and forms the absolute horizontal luma gradient. It accumulates gradients above a threshold inside a programmable centre window and publishes one sharpness score per frame. It also tracks the peak score and the frame index of that peak across a focus sweep, so the step controller can return the lens to best focus.

Parameters:
ACC_W, 32, width of accumulator and score outputs
CNT_W, 12, width of internal H/V counters and window bounds
FRM_W, 10, width of frame index counter

Ports:
VIDEO_CLK  in  1  pixel clock; all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
VS  in  1  vertical sync, negative pulse (already normalised upstream)
DE  in  1  active-pixel enable
iR  in  8  red
iG  in  8  green
iB  in  8  blue
THRESH  in  8  gradient noise threshold
H_START  in  CNT_W  window first pixel (inclusive)
H_END  in  CNT_W  window last pixel (inclusive)
V_START  in  CNT_W  window first line (inclusive)
V_END  in  CNT_W  window last line (inclusive)
CLR_PEAK  in  1  one-cycle pulse: restart sweep (clear peak, frame index)
SCORE  out  ACC_W  last completed frame score
SCORE_VALID  out  1  one-cycle pulse when SCORE updates
PEAK_SCORE  out  ACC_W  max SCORE since last CLR_PEAK
PEAK_FRAME  out  FRM_W  frame index at which PEAK_SCORE occurred
FRAME_IDX  out  FRM_W  frames completed since last CLR_PEAK
IN_WIN  out  1  registered, high while current pixel is inside window (overlay use)

Behaviour:
- Reset (async, RESET_N low): all outputs 0, accumulator 0, counters 0, pipeline registers 0, VS edge register 1.
- Counters: H_CNT increments on each DE-high cycle and clears on DE falling edge. V_CNT increments on each DE falling edge and clears while VS low. Both hold at all-ones; they never wrap.
- Window: in_win = DE & H_START<=H_CNT<=H_END & V_START<=V_CNT<=V_END, using pre-increment counts (first pixel of a line is 0, first line is 0). If START>END on either axis, the window is empty and the score is 0.
- Stage 1: Y = (77*iR + 150*iG + 29*iB) >> 8, 8-bit, unsigned 16-bit intermediate. Register Y, in_win, and first_px (DE & H_CNT==0).
- Stage 2: G = |Y - Y_prev|, 8-bit. Y_prev is Stage-1 Y of the previous DE cycle. G is forced 0 when first_px, so there is no gradient across line boundaries.
- Stage 3: if in_win_d and G > THRESH, acc += G. Saturate at 2^ACC_W-1, no wrap.
- Pixel-to-accumulator latency: 3 cycles.
- Frame end: fe = VS_d1 & ~VS (VS falling edge). fe is delayed 3 cycles (fe_d3) to drain the pipeline. On fe_d3:
  - SCORE <= acc; SCORE_VALID = 1 for exactly that cycle.
  - acc <= 0.
  - FRAME_IDX <= FRAME_IDX+1, saturating at all-ones.
- Peak: on fe_d3, if acc > PEAK_SCORE, then PEAK_SCORE <= acc and PEAK_FRAME <= FRAME_IDX (pre-increment value). Ties keep the earlier frame.
- CLR_PEAK: clears PEAK_SCORE, PEAK_FRAME and FRAME_IDX. It does not touch acc or SCORE.
  - If CLR_PEAK coincides with fe_d3: SCORE updates normally, and the clear then applies with the new frame as frame 0. Result: PEAK_SCORE=acc, PEAK_FRAME=0, FRAME_IDX=1.
- A VS falling edge with no preceding DE still produces a frame with SCORE=0.
- Window registers are sampled every cycle. Software changes them only during VS low; a mid-frame change gives an undefined score for that frame only.
- IN_WIN is Stage-1 in_win (1-cycle latency).
- Reset mid-frame: everything returns to reset values. The first SCORE_VALID after release covers the partial frame.

Test Plan:
- Flat grey frame (R=G=B=128), window 0..639 x 0..479, THRESH=0 -> SCORE=0 with one SCORE_VALID pulse, 3 cycles after VS fall +1.
- Vertical stripes alternating Y=0/255 every pixel, 640x480, window 100..199 x 10..19, THRESH=10 -> SCORE=100*10*255=255000; no contribution from the line-start pixel.
- Same stripes with THRESH=255 -> SCORE=0. With THRESH=254 -> SCORE=255000.
- Three frames with stripe amplitudes 50, 200, 100 after CLR_PEAK -> PEAK_SCORE equals the frame-1 score, PEAK_FRAME=1, FRAME_IDX=3. A repeat of amplitude 200 keeps PEAK_FRAME=1.
- Force acc near max (ACC_W=16, full-frame stripes) -> SCORE=65535, no wrap.
- CLR_PEAK on the fe_d3 cycle -> PEAK_SCORE=that frame's score, PEAK_FRAME=0, FRAME_IDX=1.
- RESET_N asserted mid-line -> outputs 0 immediately. The next frame scores from the first full pixel after release.

Source files
------------

// File: rtl/focus_sharpness_acc.sv
// focus_sharpness_acc: per-frame focus measure for the autofocus loop.
// The RGB stream is converted to luma, and the absolute horizontal luma
// gradient is formed. Gradients above THRESH that fall inside a centre window
// are summed into one score per frame. The peak score and the frame index of
// that peak are tracked across a lens sweep, so the VCM step controller can
// return the lens to best focus.
module focus_sharpness_acc #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 12,
  parameter int FRM_W = 10
) (
  input  logic             VIDEO_CLK,
  input  logic             RESET_N,
  input  logic             VS,
  input  logic             DE,
  input  logic [7:0]       iR,
  input  logic [7:0]       iG,
  input  logic [7:0]       iB,
  input  logic [7:0]       THRESH,
  input  logic [CNT_W-1:0] H_START,
  input  logic [CNT_W-1:0] H_END,
  input  logic [CNT_W-1:0] V_START,
  input  logic [CNT_W-1:0] V_END,
  input  logic             CLR_PEAK,
  output logic [ACC_W-1:0] SCORE,
  output logic             SCORE_VALID,
  output logic [ACC_W-1:0] PEAK_SCORE,
  output logic [FRM_W-1:0] PEAK_FRAME,
  output logic [FRM_W-1:0] FRAME_IDX,
  output logic             IN_WIN
);

  // The frame-end strobe is delayed by the pixel pipeline depth. This lets the
  // last pixel of a frame reach the accumulator before the score is taken.
  localparam int DRAIN = 3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [FRM_W-1:0] FRM_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef struct packed {
    logic       de;
    logic       win;
    logic       first;
    logic [7:0] y;
  } s1_t;

  typedef struct packed {
    logic       win;
    logic [7:0] g;
  } s2_t;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             de_d1, vs_d1;
  logic             de_fall, fe, fe_d3;
  logic             in_win, first_px;
  logic [15:0]      y_sum;
  logic [7:0]       y_lum;
  s1_t              s1;
  s2_t              s2;
  logic [7:0]       y_prev, g_abs;
  logic [DRAIN:1]   fe_pipe;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             acc_add;

  assign de_fall = de_d1 & ~DE;
  assign fe      = vs_d1 & ~VS;
  assign fe_d3   = fe_pipe[DRAIN];

  // Edge-detect registers for DE and VS. VS resets high, so that coming out of
  // reset with VS high does not fake a frame end.
  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      de_d1 <= 1'b0;
      vs_d1 <= 1'b1;
    end else begin
      de_d1 <= DE;
      vs_d1 <= VS;
    end
  end

  // Horizontal pixel counter. It counts active pixels, restarts after each
  // line, and sticks at all-ones.
  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N)
      h_cnt <= '0;
    else if (DE) begin
      if (h_cnt != CNT_MAX) h_cnt <= h_cnt + 1'b1;
    end else if (de_fall)
      h_cnt <= '0;
  end

  // Vertical line counter. It is held at zero through vertical sync, counts
  // line ends, and sticks at all-ones.
  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N)
      v_cnt <= '0;
    else if (!VS)
      v_cnt <= '0;
    else if (de_fall && v_cnt != CNT_MAX)
      v_cnt <= v_cnt + 1'b1;
  end

  // Window test and line-start flag. Both use the counts before this pixel's
  // increment. An inverted window (START > END) never matches.
  always_comb begin
    in_win   = DE && (h_cnt >= H_START) && (h_cnt <= H_END) &&
               (v_cnt >= V_START) && (v_cnt <= V_END);
    first_px = DE && (h_cnt == '0);
    // The weights sum to 256, so the 16-bit sum cannot overflow (max 65280).
    y_sum    = 16'd77 * {8'd0, iR} + 16'd150 * {8'd0, iG} + 16'd29 * {8'd0, iB};
    y_lum    = 8'(y_sum >> 8);
  end

  // Stage 1: register luma with its window, line-start and DE qualifiers.
  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N)
      s1 <= '0;
    else
      s1 <= '{de: DE, win: in_win, first: first_px, y: y_lum};
  end

  assign IN_WIN = s1.win;

  // Absolute difference against the previous active pixel's luma.
  always_comb begin
    g_abs = (s1.y >= y_prev) ? (s1.y - y_prev) : (y_prev - s1.y);
  end

  // Stage 2: gradient register. Y_prev advances only on active pixels. The
  // gradient is zeroed at line start, so no edge is seen across the wrap.
  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2     <= '0;
      y_prev <= '0;
    end else begin
      s2.win <= s1.win;
      s2.g   <= s1.first ? 8'd0 : g_abs;
      if (s1.de) y_prev <= s1.y;
    end
  end

  // One extra carry bit detects accumulator overflow.
  always_comb begin
    acc_add = s2.win && (s2.g > THRESH);
    acc_sum = {1'b0, acc} + {{(ACC_W-7){1'b0}}, s2.g};
  end

  // Frame-end strobe delay line. It is aligned with the pixel pipeline drain.
  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N)
      fe_pipe <= '0;
    else
      fe_pipe <= {fe_pipe[DRAIN-1:1], fe};
  end

  // Stage 3: saturating accumulator. It restarts at each drained frame end.
  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N)
      acc <= '0;
    else if (fe_d3)
      acc <= '0;
    else if (acc_add)
      acc <= acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];
  end

  // Publish the score once per frame, with a single-cycle valid pulse.
  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      SCORE       <= '0;
      SCORE_VALID <= 1'b0;
    end else begin
      SCORE_VALID <= fe_d3;
      if (fe_d3) SCORE <= acc;
    end
  end

  // Sweep tracking. CLR_PEAK always wins. When it lands on a frame end, the
  // frame just finished becomes frame 0 of the new sweep. Ties keep the
  // earlier frame.
  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PEAK_SCORE <= '0;
      PEAK_FRAME <= '0;
      FRAME_IDX  <= '0;
    end else if (CLR_PEAK && fe_d3) begin
      PEAK_SCORE <= acc;
      PEAK_FRAME <= '0;
      FRAME_IDX  <= FRM_W'(1);
    end else if (CLR_PEAK) begin
      PEAK_SCORE <= '0;
      PEAK_FRAME <= '0;
      FRAME_IDX  <= '0;
    end else if (fe_d3) begin
      if (acc > PEAK_SCORE) begin
        PEAK_SCORE <= acc;
        PEAK_FRAME <= FRAME_IDX;
      end
      if (FRAME_IDX != FRM_MAX) FRAME_IDX <= FRAME_IDX + 1'b1;
    end
  end

endmodule

// File: tb/tb_focus_sharpness_acc.sv
// Bench for focus_sharpness_acc. Directed frames are generated from a small
// pattern set. A frame-level model predicts each score from the pixels it
// sends. A per-cycle monitor checks the 32-bit and 16-bit instances against
// that model. Literal expectations pin the key numbers.
module tb_focus_sharpness_acc;
  localparam int CNT_W = 12, FRM_W = 10;
  localparam int FW = 40, FH = 8, HBLK = 4;

  logic             VIDEO_CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             VS = 1'b1, DE = 1'b0, CLR_PEAK = 1'b0;
  logic [7:0]       iR = '0, iG = '0, iB = '0, THRESH = '0;
  logic [CNT_W-1:0] H_START = '0, H_END = '0, V_START = '0, V_END = '0;

  logic [31:0]      SCORE, PEAK_SCORE;
  logic             SCORE_VALID, IN_WIN;
  logic [FRM_W-1:0] PEAK_FRAME, FRAME_IDX;
  logic [15:0]      score16, peak16;
  logic             valid16, inwin16;
  logic [FRM_W-1:0] pf16, idx16;

  focus_sharpness_acc #(.ACC_W(32), .CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
    .VIDEO_CLK(VIDEO_CLK), .RESET_N(RESET_N), .VS(VS), .DE(DE),
    .iR(iR), .iG(iG), .iB(iB), .THRESH(THRESH),
    .H_START(H_START), .H_END(H_END), .V_START(V_START), .V_END(V_END),
    .CLR_PEAK(CLR_PEAK), .SCORE(SCORE), .SCORE_VALID(SCORE_VALID),
    .PEAK_SCORE(PEAK_SCORE), .PEAK_FRAME(PEAK_FRAME), .FRAME_IDX(FRAME_IDX),
    .IN_WIN(IN_WIN));

  focus_sharpness_acc #(.ACC_W(16), .CNT_W(CNT_W), .FRM_W(FRM_W)) dut16 (
    .VIDEO_CLK(VIDEO_CLK), .RESET_N(RESET_N), .VS(VS), .DE(DE),
    .iR(iR), .iG(iG), .iB(iB), .THRESH(THRESH),
    .H_START(H_START), .H_END(H_END), .V_START(V_START), .V_END(V_END),
    .CLR_PEAK(CLR_PEAK), .SCORE(score16), .SCORE_VALID(valid16),
    .PEAK_SCORE(peak16), .PEAK_FRAME(pf16), .FRAME_IDX(idx16),
    .IN_WIN(inwin16));

  always #5 VIDEO_CLK = ~VIDEO_CLK;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct {longint due; longint raw;} pend_t;
  longint frame_q[$];
  pend_t  pend[$];
  pend_t  pe;
  longint cyc = 0;
  longint m_score = 0, m_score16 = 0, m_peak = 0, m_peak16 = 0;
  int     m_pf = 0, m_pf16 = 0, m_idx = 0;
  bit     m_valid = 0, m_inwin = 0, vs_q = 1;
  int     cur_x = 0, cur_y = 0;
  bit     cur_de = 0;

  function automatic bit in_window(int x, int y);
    return x >= int'(H_START) && x <= int'(H_END) &&
           y >= int'(V_START) && y <= int'(V_END);
  endfunction

  function automatic longint sat(longint v, int w);
    longint lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // Pattern 0: flat grey. Pattern 1: grey stripes of amplitude a.
  // Pattern 2: colour ramp.
  function automatic void pix(input int p, input int a, input int x, input int y,
                              output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
    case (p)
      0: begin r = 8'd128; g = 8'd128; b = 8'd128; end
      1: begin r = (x % 2) ? 8'(a) : 8'd0; g = r; b = r; end
      default: begin r = 8'(x*7 + y*3); g = 8'(x*13); b = 8'(255 - x*3); end
    endcase
  endfunction

  function automatic longint frame_sum(int p, int a);
    longint s = 0;
    int yl, yp = 0, gr;
    logic [7:0] r, g, b;
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) begin
        pix(p, a, x, y, r, g, b);
        yl = (77*r + 150*g + 29*b) / 256;
        gr = (x == 0) ? 0 : ((yl > yp) ? yl - yp : yp - yl);
        if (in_window(x, y) && gr > int'(THRESH)) s += gr;
        yp = yl;
      end
    return s;
  endfunction

  // Monitor: update the model at each edge, then compare just after it.
  always @(posedge VIDEO_CLK) begin
    cyc++;
    if (!RESET_N) begin
      m_score = 0; m_score16 = 0; m_peak = 0; m_peak16 = 0;
      m_pf = 0; m_pf16 = 0; m_idx = 0; m_valid = 0; m_inwin = 0; vs_q = 1;
      pend.delete(); frame_q.delete();
    end else begin
      m_valid = 0;
      m_inwin = cur_de && in_window(cur_x, cur_y);
      if (vs_q && !VS) begin
        if (frame_q.size() == 0) chk("frame_queue_nonempty", 0, 1);
        else pend.push_back('{cyc + 3, frame_q.pop_front()});
      end
      vs_q = VS;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        pe = pend.pop_front();
        m_score = sat(pe.raw, 32); m_score16 = sat(pe.raw, 16); m_valid = 1;
        if (CLR_PEAK) begin
          m_peak = m_score; m_peak16 = m_score16; m_pf = 0; m_pf16 = 0; m_idx = 1;
        end else begin
          if (m_score > m_peak) begin m_peak = m_score; m_pf = m_idx; end
          if (m_score16 > m_peak16) begin m_peak16 = m_score16; m_pf16 = m_idx; end
          if (m_idx < 1023) m_idx++;
        end
      end else if (CLR_PEAK) begin
        m_peak = 0; m_peak16 = 0; m_pf = 0; m_pf16 = 0; m_idx = 0;
      end
    end
    #1;
    chk("score", SCORE, m_score);
    chk("score_valid", SCORE_VALID, m_valid);
    chk("peak_score", PEAK_SCORE, m_peak);
    chk("peak_frame", PEAK_FRAME, m_pf);
    chk("frame_idx", FRAME_IDX, m_idx);
    chk("in_win", IN_WIN, m_inwin);
    chk("score16", score16, m_score16);
    chk("valid16", valid16, m_valid);
    chk("peak16", peak16, m_peak16);
    chk("peak_frame16", pf16, m_pf16);
    chk("frame_idx16", idx16, m_idx);
    chk("in_win16", inwin16, m_inwin);
  end

  // ---------------- stimulus ----------------
  task automatic drive_line(int p, int a, int y, int npix);
    for (int x = 0; x < npix; x++) begin
      @(negedge VIDEO_CLK);
      DE = 1'b1; pix(p, a, x, y, iR, iG, iB);
      cur_x = x; cur_y = y; cur_de = 1'b1;
    end
  endtask

  task automatic blank(int n);
    repeat (n) begin
      @(negedge VIDEO_CLK);
      DE = 1'b0; iR = '0; iG = '0; iB = '0; cur_de = 1'b0;
    end
  endtask

  // VS is held low for 4 cycles. CLR_PEAK can be placed on the drained
  // frame-end cycle, 3 edges after VS is first sampled low.
  task automatic end_frame(longint raw, bit clr_at_fe);
    frame_q.push_back(raw);
    @(negedge VIDEO_CLK); VS = 1'b0;
    repeat (2) @(negedge VIDEO_CLK);
    @(negedge VIDEO_CLK); CLR_PEAK = clr_at_fe;
    @(negedge VIDEO_CLK); CLR_PEAK = 1'b0; VS = 1'b1;
    repeat (4) @(negedge VIDEO_CLK);
  endtask

  task automatic send_frame(int p, int a, bit clr_at_fe);
    for (int y = 0; y < FH; y++) begin
      drive_line(p, a, y, FW);
      blank(HBLK);
    end
    end_frame(frame_sum(p, a), clr_at_fe);
  endtask

  task automatic set_win(int hs, int he, int vs0, int ve, int th);
    H_START = CNT_W'(hs); H_END = CNT_W'(he);
    V_START = CNT_W'(vs0); V_END = CNT_W'(ve); THRESH = 8'(th);
  endtask

  task automatic lit(string nm, logic [63:0] act, logic [63:0] model, logic [63:0] exp);
    chk({nm, "_dut"}, act, exp);
    chk({nm, "_model"}, model, exp);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge VIDEO_CLK);
    chk("rst_score", SCORE, 0);
    chk("rst_valid", SCORE_VALID, 0);
    chk("rst_frame_idx", FRAME_IDX, 0);
    chk("rst_in_win", IN_WIN, 0);
    RESET_N = 1'b1;
    blank(3);

    // Flat grey: no gradient anywhere.
    set_win(0, 39, 0, 7, 0);
    send_frame(0, 0, 0);
    lit("flat", SCORE, m_score, 0);

    // Stripes of 255 in a 20x4 window: 80 * 255.
    set_win(10, 29, 2, 5, 10);
    send_frame(1, 255, 0);
    lit("stripe", SCORE, m_score, 20400);
    THRESH = 8'd255;
    send_frame(1, 255, 0);
    lit("thr255", SCORE, m_score, 0);
    THRESH = 8'd254;
    send_frame(1, 255, 0);
    lit("thr254", SCORE, m_score, 20400);

    // Colour ramp exercises the luma weights (model only).
    set_win(0, 39, 0, 7, 3);
    send_frame(2, 0, 0);

    // An inverted window scores nothing.
    set_win(30, 10, 0, 7, 0);
    send_frame(1, 255, 0);
    lit("empty_win", SCORE, m_score, 0);

    // Sweep: amplitudes 50, 200, 100, then 200 again (a tie keeps frame 1).
    @(negedge VIDEO_CLK); CLR_PEAK = 1'b1;
    @(negedge VIDEO_CLK); CLR_PEAK = 1'b0;
    set_win(10, 29, 2, 5, 10);
    send_frame(1, 50, 0);
    send_frame(1, 200, 0);
    send_frame(1, 100, 0);
    lit("sweep_peak", PEAK_SCORE, m_peak, 16000);
    lit("sweep_pf", PEAK_FRAME, m_pf, 1);
    lit("sweep_idx", FRAME_IDX, m_idx, 3);
    send_frame(1, 200, 0);
    lit("tie_pf", PEAK_FRAME, m_pf, 1);
    lit("tie_idx", FRAME_IDX, m_idx, 4);

    // VS pulse with no active video still yields a zero score.
    end_frame(0, 0);
    lit("no_de", SCORE, m_score, 0);

    // Full-window stripes: 8 * 39 * 255 overflows 16 bits.
    set_win(0, 39, 0, 7, 0);
    send_frame(1, 255, 0);
    lit("full32", SCORE, m_score, 79560);
    lit("sat16", score16, m_score16, 65535);

    // CLR_PEAK coinciding with the drained frame end.
    set_win(10, 29, 2, 5, 10);
    send_frame(1, 100, 1);
    lit("clr_fe_peak", PEAK_SCORE, m_peak, 8000);
    lit("clr_fe_pf", PEAK_FRAME, m_pf, 0);
    lit("clr_fe_idx", FRAME_IDX, m_idx, 1);

    // Reset in mid-line: outputs clear without waiting for a clock edge.
    drive_line(1, 255, 0, FW);
    blank(HBLK);
    drive_line(1, 255, 1, 15);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_score", SCORE, 0);
    chk("async_peak", PEAK_SCORE, 0);
    chk("async_idx", FRAME_IDX, 0);
    chk("async_in_win", IN_WIN, 0);
    blank(3);
    RESET_N = 1'b1;
    blank(2);
    send_frame(1, 255, 0);
    lit("post_rst_score", SCORE, m_score, 20400);
    lit("post_rst_idx", FRAME_IDX, m_idx, 1);

    blank(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
